// File: rtl/pacman_pkg.sv
// Shared Pac-Man definitions: joystick/heading direction codes used by the
// motion block, the joystick front end and the maze ROM.
package pacman_pkg;

    typedef enum logic [2:0] {
        NONE  = 3'b000,
        UP    = 3'b001,
        DOWN  = 3'b010,
        RIGHT = 3'b011,
        LEFT  = 3'b100
    } dir_t;

    // Codes 101..111 are not directions; the joystick is treated as centred.
    function automatic dir_t sanitize_dir(input logic [2:0] code);
        return (code <= 3'b100) ? dir_t'(code) : NONE;
    endfunction

endpackage

// File: rtl/pacman_motion_if.sv
// Joystick/maze-side signals of the motion block: direction in, wall query
// in, heading/position/step out.
interface pacman_motion_if;
    logic [2:0] DIR;
    logic       BLOCKED;
    logic [2:0] HEADING;
    logic [4:0] POS_X;
    logic [4:0] POS_Y;
    logic       STEP;

    modport master (
        output DIR, BLOCKED,
        input  HEADING, POS_X, POS_Y, STEP
    );

    modport slave (
        input  DIR, BLOCKED,
        output HEADING, POS_X, POS_Y, STEP
    );
endinterface

// File: rtl/dir_debounce.sv
// Samples the joystick code on a periodic strobe and accepts a non-centred
// direction once it has been seen on DEBOUNCE_N consecutive strobes.
module dir_debounce
    import pacman_pkg::*;
#(
    parameter int SAMPLE_DIV = 2_000_000,
    parameter int DEBOUNCE_N = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] dir,
    output dir_t       accepted,
    output logic       load
);

    localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int MW = $clog2(DEBOUNCE_N + 1);

    logic [CW-1:0] cnt_reg, cnt_next;
    dir_t          cand_reg, cand_next;
    logic [MW-1:0] match_reg, match_next;
    logic          strobe;
    dir_t          code;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg   <= '0;
            cand_reg  <= NONE;
            match_reg <= '0;
        end else begin
            cnt_reg   <= cnt_next;
            cand_reg  <= cand_next;
            match_reg <= match_next;
        end
    end

    always_comb begin
        strobe     = (cnt_reg == CW'(SAMPLE_DIV - 1));
        cnt_next   = strobe ? '0 : cnt_reg + CW'(1);
        code       = sanitize_dir(dir);
        cand_next  = cand_reg;
        match_next = match_reg;
        if (strobe) begin
            if (code == cand_reg) begin
                if (match_reg != MW'(DEBOUNCE_N))
                    match_next = match_reg + MW'(1);
            end else begin
                cand_next  = code;
                match_next = MW'(1);
            end
        end
        // Load on the qualifying strobe itself so HEADING moves on the next cycle.
        accepted = cand_next;
        load     = strobe && (match_next == MW'(DEBOUNCE_N)) && (cand_next != NONE);
    end

endmodule

// File: rtl/pacman_motion.sv
// Pac-Man tile motion: debounced joystick heading and a periodic one-tile
// step with maze wrap-around, suppressed when the maze reports a wall.
module pacman_motion
    import pacman_pkg::*;
#(
    parameter int SAMPLE_DIV = 2_000_000,
    parameter int DEBOUNCE_N = 3,
    parameter int STEP_DIV   = 10_000_000,
    parameter int GRID_W     = 28,
    parameter int GRID_H     = 31,
    parameter int START_X    = 13,
    parameter int START_Y    = 23
) (
    input  logic           CLK_100MHz,
    input  logic           RST,
    pacman_motion_if.slave bus
);

    localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    logic [SW-1:0] step_cnt_reg, step_cnt_next;
    dir_t          heading_reg, heading_next;
    logic [4:0]    pos_x_reg, pos_x_next;
    logic [4:0]    pos_y_reg, pos_y_next;
    logic          step_tc;
    logic          move;
    dir_t          accepted;
    logic          load;

    dir_debounce #(
        .SAMPLE_DIV (SAMPLE_DIV),
        .DEBOUNCE_N (DEBOUNCE_N)
    ) u_debounce (
        .clk      (CLK_100MHz),
        .rst      (RST),
        .dir      (bus.DIR),
        .accepted (accepted),
        .load     (load)
    );

    always_ff @(posedge CLK_100MHz or posedge RST) begin
        if (RST) begin
            step_cnt_reg <= '0;
            heading_reg  <= NONE;
            pos_x_reg    <= 5'(START_X);
            pos_y_reg    <= 5'(START_Y);
        end else begin
            step_cnt_reg <= step_cnt_next;
            heading_reg  <= heading_next;
            pos_x_reg    <= pos_x_next;
            pos_y_reg    <= pos_y_next;
        end
    end

    always_comb begin
        step_tc       = (step_cnt_reg == SW'(STEP_DIV - 1));
        step_cnt_next = step_tc ? '0 : step_cnt_reg + SW'(1);
        // A heading accepted this cycle only affects later steps.
        heading_next  = load ? accepted : heading_reg;
        move          = step_tc && (heading_reg != NONE) && !bus.BLOCKED;
        pos_x_next    = pos_x_reg;
        pos_y_next    = pos_y_reg;
        if (move) begin
            case (heading_reg)
                UP:      pos_y_next = (pos_y_reg == 5'd0) ? 5'(GRID_H - 1) : pos_y_reg - 5'd1;
                DOWN:    pos_y_next = (pos_y_reg == 5'(GRID_H - 1)) ? 5'd0 : pos_y_reg + 5'd1;
                RIGHT:   pos_x_next = (pos_x_reg == 5'(GRID_W - 1)) ? 5'd0 : pos_x_reg + 5'd1;
                LEFT:    pos_x_next = (pos_x_reg == 5'd0) ? 5'(GRID_W - 1) : pos_x_reg - 5'd1;
                default: ;
            endcase
        end
    end

    assign bus.HEADING = heading_reg;
    assign bus.POS_X   = pos_x_reg;
    assign bus.POS_Y   = pos_y_reg;
    assign bus.STEP    = move;

endmodule

// File: tb/tb_pacman_motion.sv
// Directed bench for pacman_motion with SAMPLE_DIV=4, STEP_DIV=16: cycle k
// counts rising edges since reset release; strobes at k%4==3, steps at k%16==15.
module tb_pacman_motion;

    logic clk = 1'b0;
    logic rst;
    int   kk;
    int   steps_seen;
    int   total = 0;
    int   bad   = 0;

    pacman_motion_if bus ();

    pacman_motion #(
        .SAMPLE_DIV (4),
        .DEBOUNCE_N (3),
        .STEP_DIV   (16),
        .GRID_W     (28),
        .GRID_H     (31),
        .START_X    (13),
        .START_Y    (23)
    ) dut (
        .CLK_100MHz (clk),
        .RST        (rst),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("k=%0d %s observed=%0d expected=%0d", kk, tag, obs, exp);
    endtask

    // Hold reset across one rising edge and release on a falling edge (k=0).
    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        kk = 0;
        steps_seen = 0;
    endtask

    task automatic run_to(input int target);
        while (kk < target) begin
            @(negedge clk);
            kk++;
            if (bus.STEP === 1'b1) steps_seen++;
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.DIR = 3'b000;
        bus.BLOCKED = 1'b0;
        kk = 0;
        steps_seen = 0;
        @(negedge clk);
        chk("rst_heading", int'(bus.HEADING), 0);
        chk("rst_pos_x", int'(bus.POS_X), 13);
        chk("rst_pos_y", int'(bus.POS_Y), 23);
        chk("rst_step", int'(bus.STEP), 0);

        // Accept RIGHT on the third strobe, then step right.
        bus.DIR = 3'b011;
        do_reset();
        run_to(11);
        chk("acc_before", int'(bus.HEADING), 0);
        run_to(12);
        chk("acc_right", int'(bus.HEADING), 3);
        run_to(15);
        chk("step_pulse", int'(bus.STEP), 1);
        chk("x_before_step", int'(bus.POS_X), 13);
        run_to(16);
        chk("step_x14", int'(bus.POS_X), 14);
        chk("step_low", int'(bus.STEP), 0);
        run_to(31);
        chk("single_step", steps_seen, 2);

        // Interrupted run of RIGHT restarts the count.
        bus.DIR = 3'b011;
        do_reset();
        run_to(8);
        bus.DIR = 3'b000;
        run_to(12);
        bus.DIR = 3'b011;
        run_to(17);
        chk("interrupt_hold", int'(bus.HEADING), 0);
        chk("interrupt_x", int'(bus.POS_X), 13);

        // Illegal code 111 held for five strobes is never accepted.
        bus.DIR = 3'b111;
        do_reset();
        run_to(21);
        chk("illegal_hold", int'(bus.HEADING), 0);
        chk("illegal_nostep", steps_seen, 0);
        chk("illegal_x", int'(bus.POS_X), 13);

        // LEFT from X=13 reaches 0 after 13 steps, then wraps to 27.
        bus.DIR = 3'b100;
        do_reset();
        run_to(208);
        chk("left_x0", int'(bus.POS_X), 0);
        run_to(223);
        chk("left_wrap_step", int'(bus.STEP), 1);
        run_to(224);
        chk("left_wrap_x27", int'(bus.POS_X), 27);

        // UP from Y=23 reaches 0 after 23 steps, then wraps to 30.
        bus.DIR = 3'b001;
        do_reset();
        run_to(368);
        chk("up_y0", int'(bus.POS_Y), 0);
        run_to(384);
        chk("up_wrap_y30", int'(bus.POS_Y), 30);
        chk("up_x_same", int'(bus.POS_X), 13);

        // Wall ahead for three step terminals: no movement, no STEP.
        bus.DIR = 3'b011;
        bus.BLOCKED = 1'b1;
        do_reset();
        run_to(48);
        chk("blocked_nostep", steps_seen, 0);
        chk("blocked_x", int'(bus.POS_X), 13);
        bus.BLOCKED = 1'b0;
        run_to(64);
        chk("unblocked_x", int'(bus.POS_X), 14);

        // DOWN accepted on the same cycle as a step: that step still goes right.
        bus.DIR = 3'b011;
        do_reset();
        run_to(20);
        bus.DIR = 3'b010;
        run_to(31);
        chk("coinc_old_heading", int'(bus.HEADING), 3);
        run_to(32);
        chk("coinc_new_heading", int'(bus.HEADING), 2);
        chk("coinc_x15", int'(bus.POS_X), 15);
        chk("coinc_y23", int'(bus.POS_Y), 23);
        run_to(48);
        chk("coinc_next_y24", int'(bus.POS_Y), 24);
        chk("coinc_next_x15", int'(bus.POS_X), 15);

        // Asynchronous reset between edges, then a fresh debounce after release.
        run_to(50);
        #2 rst = 1'b1;
        #1;
        chk("async_heading", int'(bus.HEADING), 0);
        chk("async_pos_x", int'(bus.POS_X), 13);
        chk("async_pos_y", int'(bus.POS_Y), 23);
        chk("async_step", int'(bus.STEP), 0);
        @(negedge clk);
        rst = 1'b0;
        kk = 0;
        steps_seen = 0;
        run_to(11);
        chk("resume_no_early", int'(bus.HEADING), 0);
        run_to(12);
        chk("resume_accept", int'(bus.HEADING), 2);
        run_to(16);
        chk("resume_y24", int'(bus.POS_Y), 24);
        chk("resume_one_step", steps_seen, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pacman_motion.md
PACMAN_MOTION -- requirements
Module: pacman_motion

Interface
REQ-001 Parameter SAMPLE_DIV, default 2_000_000, is the clock cycles between DIR samples (50 Hz).
REQ-002 Parameter DEBOUNCE_N, default 3, is the consecutive identical samples needed to accept a direction.
REQ-003 Parameter STEP_DIV, default 10_000_000, is the clock cycles between movement steps (10 Hz).
REQ-004 Parameters GRID_W and GRID_H, defaults 28 and 31, are the maze size in tiles.
REQ-005 Parameters START_X and START_Y, defaults 13 and 23, are the reset tile.
REQ-006 Port CLK_100MHz, input, 1 bit, is the single system clock.
REQ-007 Port RST, input, 1 bit, is the reset: asynchronous, active-high.
REQ-008 Port DIR, input, 3 bits, is the joystick direction code (000 none, 001 up, 010 down, 011 right, 100 left), asynchronous to sampling.
REQ-009 Port BLOCKED, input, 1 bit, is high when the tile adjacent in HEADING is a wall; it is combinational from the maze ROM using POS_X, POS_Y and HEADING.
REQ-010 Port HEADING, output, 3 bits, is the accepted direction code.
REQ-011 Port POS_X, output, 5 bits, is the current tile column.
REQ-012 Port POS_Y, output, 5 bits, is the current tile row, with 0 at the top.
REQ-013 Port STEP, output, 1 bit, is a one-cycle pulse on each cycle the position changes.

Function
REQ-014 A free-running sample counter SHALL count 0..SAMPLE_DIV-1 and assert an internal sample strobe for one cycle at the terminal count.
REQ-015 On a sample strobe, DIR codes 101, 110 and 111 SHALL be treated as 000.
REQ-016 On a strobe, if the sampled code equals the candidate, the match count SHALL increment, saturating at DEBOUNCE_N; otherwise candidate becomes the sampled code and count becomes 1.
REQ-017 When count equals DEBOUNCE_N and candidate is nonzero, HEADING SHALL load candidate on the following cycle.
REQ-018 Candidate 000 SHALL never be accepted; HEADING holds its last value while the joystick is centred.
REQ-019 A free-running step counter SHALL count 0..STEP_DIV-1, independent of the sample counter.
REQ-020 At step terminal count, if HEADING is nonzero and BLOCKED is low, the position SHALL update by one tile and STEP SHALL pulse high for that one cycle.
REQ-021 Step moves: up decrements Y, down increments Y, right increments X, left decrements X.
REQ-022 Wrap-around: X=0 moving left goes to GRID_W-1; X=GRID_W-1 moving right goes to 0; Y wraps identically using GRID_H.
REQ-023 At step terminal count, if BLOCKED is high or HEADING is 000, the position SHALL hold and STEP SHALL stay low.
REQ-024 When a heading update and a step occur on the same cycle, the step SHALL use the registered HEADING from before the update; the new heading applies from the next step.
REQ-025 Latency from the qualifying (DEBOUNCE_N-th) strobe to the HEADING change SHALL be exactly 1 cycle.

Reset
REQ-026 While RST is high: HEADING=000, POS_X=START_X, POS_Y=START_Y, STEP=0, both counters 0, candidate 000, match count 0.
REQ-027 RST asserted mid-step or mid-debounce SHALL discard the partial state; the first strobe after release occurs SAMPLE_DIV cycles after deassertion.

Structure
REQ-028 The direction code constants (NONE, UP, DOWN, RIGHT, LEFT) SHALL reside in shared package pacman_pkg, which the upstream joystick-position block and the maze ROM also use.
REQ-029 The sampling counter and debounce logic SHALL be one sub-module, dir_debounce, which outputs an accepted-direction value and a load pulse.
REQ-030 All state SHALL be clocked by CLK_100MHz only, with no derived clocks.

Verification (bench parameters: SAMPLE_DIV=4, STEP_DIV=16, DEBOUNCE_N=3, START 13/23)
REQ-031 Hold DIR=011 for 3 strobes -> HEADING=011 one cycle after the 3rd strobe; next step terminal gives POS_X=14 with a single-cycle STEP.
REQ-032 DIR pattern 011,011,000,011 across strobes -> HEADING stays 000 (count restarts); DIR=111 held for 5 strobes -> HEADING stays 000.
REQ-033 HEADING=100 at POS_X=0 with BLOCKED=0 -> next step gives POS_X=27; HEADING=001 at POS_Y=0 -> POS_Y=30.
REQ-034 BLOCKED=1 held across 3 step terminals -> position unchanged and STEP never asserted.
REQ-035 Accept and step terminal coincide (old HEADING=011, new 010) -> this step moves X+1, the next step moves Y+1.
REQ-036 Assert RST at an arbitrary cycle mid-step -> outputs go to reset values immediately without waiting for a clock edge, and resume per REQ-027 after release.
